byte_logic_accumulator: RTL and testbench

Sequential front end for the team's byte-wide bitwise logic units. It holds an 8-bit accumulator and accepts one command at a time over a valid/ready handshake. Each command applies AND/OR/XOR/NOT/LOAD/CLR to the accumulator, or a multi-cycle logical left shift built from repeated 1-bit shifts. It also produces a zero flag and a shift carry-out flag for downstream consumers.

---
 rtl/byte_logic_accumulator_if.sv | 26 ++
 rtl/byte_logic_accumulator.sv | 109 ++++++++++
 tb/tb_byte_logic_accumulator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/byte_logic_accumulator_if.sv
// Command/result bundle for the byte logic accumulator.
// The master drives commands; the slave returns the accumulator and its status flags.
interface byte_logic_accumulator_if #(
    parameter int SHAMT_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         op;
    logic [7:0]         operand;
    logic [SHAMT_W-1:0] shamt;
    logic [7:0]         acc;
    logic               zero;
    logic               carry;
    logic               busy;
    logic               done;

    modport master (
        output in_valid, op, operand, shamt,
        input  in_ready, acc, zero, carry, busy, done
    );

    modport slave (
        input  in_valid, op, operand, shamt,
        output in_ready, acc, zero, carry, busy, done
    );
endinterface

// File: rtl/byte_logic_accumulator.sv
// Byte-wide accumulator with bitwise ops and a multi-cycle logical left shift.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a command; single-cycle ops complete here
// SHIFT | shifting acc left one bit per cycle until cnt reaches 1
module byte_logic_accumulator #(
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter int         SHAMT_W     = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    byte_logic_accumulator_if.slave   bus
);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NOT  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [SHAMT_W-1:0] cnt, cnt_next;
    logic [7:0]         acc_q, acc_next;
    logic               carry_q, carry_next;
    logic               done_q, done_next;
    logic               accept;

    assign accept = bus.in_valid && (state == IDLE);

    // State and datapath registers; reset abandons any shift without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc_q   <= RESET_VALUE;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            acc_q   <= acc_next;
            carry_q <= carry_next;
            done_q  <= done_next;
        end
    end

    // Next-state and datapath decode; everything holds unless a command or shift step applies.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc_q;
        carry_next = carry_q;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    carry_next = 1'b0;
                    done_next  = 1'b1;
                    case (bus.op)
                        OP_LOAD: acc_next = bus.operand;
                        OP_AND:  acc_next = acc_q & bus.operand;
                        OP_OR:   acc_next = acc_q | bus.operand;
                        OP_XOR:  acc_next = acc_q ^ bus.operand;
                        OP_NOT:  acc_next = ~acc_q;
                        OP_CLR:  acc_next = 8'h00;
                        OP_SHL: begin
                            // A zero-length shift completes like any single-cycle op.
                            if (bus.shamt != '0) begin
                                cnt_next   = bus.shamt;
                                state_next = SHIFT;
                                done_next  = 1'b0;
                            end
                        end
                        OP_NOP:  acc_next = acc_q;
                        default: acc_next = acc_q;
                    endcase
                end
            end
            SHIFT: begin
                acc_next   = {acc_q[6:0], 1'b0};
                carry_next = carry_q | acc_q[7];
                cnt_next   = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state == SHIFT);
    assign bus.acc      = acc_q;
    assign bus.zero     = (acc_q == 8'h00);
    assign bus.carry    = carry_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_byte_logic_accumulator.sv
// Directed bench for byte_logic_accumulator: inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_byte_logic_accumulator;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    byte_logic_accumulator_if #(.SHAMT_W(3)) bus ();

    byte_logic_accumulator #(
        .RESET_VALUE (8'h00),
        .SHAMT_W     (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] b, input logic [2:0] s);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.operand  = b;
        bus.shamt    = s;
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] b, input logic [2:0] s);
        drive(o, b, s);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = 3'd7;
        bus.operand = 8'h00;
        bus.shamt = 3'd0;

        // reset takes effect immediately, before any clock edge
        #3 rst_n = 1'b0;
        #1;
        check("rst_acc", bus.acc, 8'h00);
        check("rst_zero", {7'b0, bus.zero}, 8'h01);
        check("rst_carry", {7'b0, bus.carry}, 8'h00);
        check("rst_ready", {7'b0, bus.in_ready}, 8'h01);
        check("rst_busy", {7'b0, bus.busy}, 8'h00);
        check("rst_done", {7'b0, bus.done}, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // back-to-back single-cycle ops
        send(3'd0, 8'hA5, 3'd0);
        check("load_acc", bus.acc, 8'hA5);
        check("load_done", {7'b0, bus.done}, 8'h01);
        check("load_zero", {7'b0, bus.zero}, 8'h00);
        send(3'd1, 8'h0F, 3'd0);
        check("and_acc", bus.acc, 8'h05);
        check("and_done", {7'b0, bus.done}, 8'h01);
        send(3'd2, 8'h30, 3'd0);
        check("or_acc", bus.acc, 8'h35);
        check("or_done", {7'b0, bus.done}, 8'h01);
        send(3'd3, 8'hFF, 3'd0);
        check("xor_acc", bus.acc, 8'hCA);
        check("xor_done", {7'b0, bus.done}, 8'h01);
        send(3'd4, 8'h00, 3'd0);
        check("not_acc", bus.acc, 8'h35);
        check("not_done", {7'b0, bus.done}, 8'h01);
        check("not_zero", {7'b0, bus.zero}, 8'h00);
        bus.in_valid = 1'b0;
        tick();
        check("idle_done", {7'b0, bus.done}, 8'h00);
        check("idle_acc", bus.acc, 8'h35);

        // SHL 3 on 0x81 with a CLR waiting during the shift
        send(3'd0, 8'h81, 3'd0);
        check("load81_acc", bus.acc, 8'h81);
        send(3'd5, 8'h00, 3'd3);
        drive(3'd6, 8'h00, 3'd0);
        check("shl3_busy0", {7'b0, bus.busy}, 8'h01);
        check("shl3_ready0", {7'b0, bus.in_ready}, 8'h00);
        check("shl3_done0", {7'b0, bus.done}, 8'h00);
        check("shl3_acc0", bus.acc, 8'h81);
        tick();
        check("shl3_busy1", {7'b0, bus.busy}, 8'h01);
        check("shl3_acc1", bus.acc, 8'h02);
        tick();
        check("shl3_busy2", {7'b0, bus.busy}, 8'h01);
        check("shl3_acc2", bus.acc, 8'h04);
        tick();
        check("shl3_busy3", {7'b0, bus.busy}, 8'h00);
        check("shl3_ready3", {7'b0, bus.in_ready}, 8'h01);
        check("shl3_done3", {7'b0, bus.done}, 8'h01);
        check("shl3_acc3", bus.acc, 8'h08);
        check("shl3_carry", {7'b0, bus.carry}, 8'h01);
        tick();
        check("clr_acc", bus.acc, 8'h00);
        check("clr_zero", {7'b0, bus.zero}, 8'h01);
        check("clr_carry", {7'b0, bus.carry}, 8'h00);
        check("clr_done", {7'b0, bus.done}, 8'h01);
        bus.in_valid = 1'b0;
        tick();
        check("clr_done_off", {7'b0, bus.done}, 8'h00);

        // maximum shift, then shift the last bit out
        send(3'd0, 8'h01, 3'd0);
        send(3'd5, 8'h00, 3'd7);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("shl7_busy", {7'b0, bus.busy}, 8'h01);
            check("shl7_nodone", {7'b0, bus.done}, 8'h00);
            tick();
        end
        check("shl7_busy_last", {7'b0, bus.busy}, 8'h01);
        tick();
        check("shl7_acc", bus.acc, 8'h80);
        check("shl7_carry", {7'b0, bus.carry}, 8'h00);
        check("shl7_done", {7'b0, bus.done}, 8'h01);
        send(3'd5, 8'h00, 3'd1);
        bus.in_valid = 1'b0;
        check("shl1_busy", {7'b0, bus.busy}, 8'h01);
        tick();
        check("shl1_acc", bus.acc, 8'h00);
        check("shl1_carry", {7'b0, bus.carry}, 8'h01);
        check("shl1_zero", {7'b0, bus.zero}, 8'h01);
        check("shl1_done", {7'b0, bus.done}, 8'h01);

        // zero-length shift and NOP
        send(3'd0, 8'h5A, 3'd0);
        send(3'd5, 8'h00, 3'd0);
        check("shl0_acc", bus.acc, 8'h5A);
        check("shl0_done", {7'b0, bus.done}, 8'h01);
        check("shl0_busy", {7'b0, bus.busy}, 8'h00);
        check("shl0_carry", {7'b0, bus.carry}, 8'h00);
        bus.in_valid = 1'b0;
        tick();
        check("shl0_done_off", {7'b0, bus.done}, 8'h00);
        send(3'd7, 8'hFF, 3'd5);
        check("nop_acc", bus.acc, 8'h5A);
        check("nop_done", {7'b0, bus.done}, 8'h01);
        check("nop_busy", {7'b0, bus.busy}, 8'h00);
        bus.in_valid = 1'b0;
        tick();
        check("nop_done_off", {7'b0, bus.done}, 8'h00);

        // reset in the middle of a shift
        send(3'd0, 8'hFF, 3'd0);
        send(3'd5, 8'h00, 3'd5);
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("mid_acc", bus.acc, 8'hFC);
        check("mid_busy", {7'b0, bus.busy}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("mrst_acc", bus.acc, 8'h00);
        check("mrst_busy", {7'b0, bus.busy}, 8'h00);
        check("mrst_done", {7'b0, bus.done}, 8'h00);
        check("mrst_ready", {7'b0, bus.in_ready}, 8'h01);
        tick();
        tick();
        check("mrst_done_hold", {7'b0, bus.done}, 8'h00);
        rst_n = 1'b1;
        send(3'd0, 8'h11, 3'd0);
        check("post_acc", bus.acc, 8'h11);
        check("post_done", {7'b0, bus.done}, 8'h01);
        bus.in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
